// File: rtl/fp64_pkg.sv
// fp64_pkg: shared binary64 / fixed-point definitions.
//   fp64_t        packed binary64 {sign, exp[10:0], mant[51:0]}
//   fixp_flags_t  conversion status {invalid, overflow, inexact}
//   d2f_cls_e     operand class decided in the unpack stage of fp64_to_fixp
// Used by the fixed->double path, the fp64 accumulator and fp64_to_fixp.
package fp64_pkg;

  localparam int          FP64_BIAS    = 1023;
  localparam logic [10:0] FP64_EXP_MAX = 11'h7FF;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] mant;
  } fp64_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } fixp_flags_t;

  // BIG: exponent too large for the integer field; TINY: below half an LSB.
  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NAN  = 3'd2,
    CLS_INF  = 3'd3,
    CLS_BIG  = 3'd4,
    CLS_TINY = 3'd5,
    CLS_NORM = 3'd6
  } d2f_cls_e;

endpackage

// File: rtl/fp64_to_fixp_shift.sv
// fp64_to_fixp_shift: combinational significand aligner.
//   sig_i    53-bit significand {1, mant}
//   sa_i     shift amount = e + FRAC_W + 1 (0..OUT_W once range-limited)
//   q_o      aligned value at twice output resolution: q_o[0] is the guard
//            bit, q_o[OUT_W+1:1] the truncated magnitude
//   sticky_o OR of every bit below the guard bit
// A right shift of up to 52 and a left shift of up to OUT_W-52 are folded
// into one left shift of a 53-bit-offset window, so the shift is unsigned.
module fp64_to_fixp_shift #(
  parameter int OUT_W = 64,
  parameter int SA_W  = 7
) (
  input  logic [52:0]      sig_i,
  input  logic [SA_W-1:0]  sa_i,
  output logic [OUT_W+1:0] q_o,
  output logic             sticky_o
);

  logic [OUT_W+53:0] wide_s;

  assign wide_s   = {{(OUT_W + 1){1'b0}}, sig_i} << sa_i;
  assign q_o      = wide_s[OUT_W+53:52];
  assign sticky_o = |wide_s[51:0];

endmodule

// File: rtl/fp64_to_fixp.sv
// fp64_to_fixp: streaming binary64 -> signed fixed-point Q(INT_W).(FRAC_W).
// Three register stages: S1 unpack/classify, S2 align (+sticky),
// S3 round/negate/saturate into the output register.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_tvalid/s_tready     input handshake, s_tdata = binary64
//   m_tvalid/m_tready     output handshake, m_tdata = OUT_W two's complement
//   m_tuser               {invalid, overflow, inexact}
// Build option: D2F_ROUND_NEAREST_EN selects round-to-nearest-even; when
// undefined the magnitude is truncated (toward zero).
module fp64_to_fixp
  import fp64_pkg::*;
#(
  parameter int INT_W  = 32,
  parameter int FRAC_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [63:0]               s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [INT_W+FRAC_W-1:0]   m_tdata,
  output logic [2:0]                m_tuser
);

  localparam int OUT_W = INT_W + FRAC_W;
  localparam int SA_W  = $clog2(OUT_W + 1);
  localparam logic signed [13:0] E_HI     = 14'(INT_W - 1);
  localparam logic signed [13:0] E_LO     = 14'(-(FRAC_W + 1));
  localparam logic signed [13:0] E_SA_OFF = 14'(FRAC_W + 1);
  localparam logic [OUT_W-1:0]   FIX_MAX  = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0]   FIX_MIN  = {1'b1, {(OUT_W - 1){1'b0}}};

  // ---------------- pipeline control ----------------
  logic v1_q, v2_q, m_tvalid_q;
  logic v1_d, v2_d, m_tvalid_d;
  logic ld3_s, adv2_s, ld2_s, adv1_s, acc_s;

  assign ld3_s    = ~m_tvalid_q | m_tready;
  assign adv2_s   = v2_q & ld3_s;
  assign ld2_s    = ~v2_q | adv2_s;
  assign adv1_s   = v1_q & ld2_s;
  assign s_tready = ~rst & (~v1_q | adv1_s);
  assign acc_s    = s_tvalid & s_tready;

  // Next-state of the per-stage valid bits.
  always_comb begin
    v1_d       = acc_s  | (v1_q & ~adv1_s);
    v2_d       = adv1_s | (v2_q & ~adv2_s);
    m_tvalid_d = adv2_s | (m_tvalid_q & ~m_tready);
  end

  // Valid-bit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  // ---------------- S1: unpack / classify ----------------
  fp64_t              in_s;
  logic signed [13:0] e_s;
  d2f_cls_e           cls_d;
  logic [SA_W-1:0]    sa_d;

  assign in_s = s_tdata;
  assign e_s  = $signed({3'b000, in_s.exp}) - 14'sd1023;
  assign sa_d = SA_W'(e_s + E_SA_OFF);

  // Operand class; exponent range checks keep the S2 shift inside OUT_W.
  always_comb begin
    cls_d = CLS_NORM;
    if (in_s.exp == 11'd0) begin
      cls_d = (in_s.mant != 52'd0) ? CLS_SUB : CLS_ZERO;
    end else if (in_s.exp == FP64_EXP_MAX) begin
      cls_d = (in_s.mant != 52'd0) ? CLS_NAN : CLS_INF;
    end else if (e_s > E_HI) begin
      cls_d = CLS_BIG;
    end else if (e_s < E_LO) begin
      cls_d = CLS_TINY;
    end else begin
      cls_d = CLS_NORM;
    end
  end

  logic            s1_sign_q;
  d2f_cls_e        s1_cls_q;
  logic [52:0]     s1_sig_q;
  logic [SA_W-1:0] s1_sa_q;

  // S1 data register, loaded on input accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_q <= 1'b0;
      s1_cls_q  <= CLS_ZERO;
      s1_sig_q  <= 53'd0;
      s1_sa_q   <= {SA_W{1'b0}};
    end else if (acc_s) begin
      s1_sign_q <= in_s.sign;
      s1_cls_q  <= cls_d;
      s1_sig_q  <= {1'b1, in_s.mant};
      s1_sa_q   <= sa_d;
    end else begin
      s1_sign_q <= s1_sign_q;
      s1_cls_q  <= s1_cls_q;
      s1_sig_q  <= s1_sig_q;
      s1_sa_q   <= s1_sa_q;
    end
  end

  // ---------------- S2: align ----------------
  logic [OUT_W+1:0] shq_s;
  logic             shst_s;

  fp64_to_fixp_shift #(.OUT_W(OUT_W), .SA_W(SA_W)) u_shift (
    .sig_i    (s1_sig_q),
    .sa_i     (s1_sa_q),
    .q_o      (shq_s),
    .sticky_o (shst_s)
  );

  logic             s2_sign_q;
  d2f_cls_e         s2_cls_q;
  logic [OUT_W+1:0] s2_q_q;
  logic             s2_sticky_q;

  // S2 data register, loaded when S1 advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= CLS_ZERO;
      s2_q_q      <= {(OUT_W + 2){1'b0}};
      s2_sticky_q <= 1'b0;
    end else if (adv1_s) begin
      s2_sign_q   <= s1_sign_q;
      s2_cls_q    <= s1_cls_q;
      s2_q_q      <= shq_s;
      s2_sticky_q <= shst_s;
    end else begin
      s2_sign_q   <= s2_sign_q;
      s2_cls_q    <= s2_cls_q;
      s2_q_q      <= s2_q_q;
      s2_sticky_q <= s2_sticky_q;
    end
  end

  // ---------------- S3: round / negate / saturate ----------------
  logic [OUT_W:0]   mag_s, mag_rnd_s;
  logic             guard_s, lost_s, rnd_inc_s, ovf_s;
  logic [OUT_W-1:0] res_d;
  fixp_flags_t      flags_d;

  assign mag_s   = s2_q_q[OUT_W+1:1];
  assign guard_s = s2_q_q[0];
  assign lost_s  = guard_s | s2_sticky_q;

`ifdef D2F_ROUND_NEAREST_EN
  assign rnd_inc_s = guard_s & (s2_sticky_q | mag_s[0]);
`else
  assign rnd_inc_s = 1'b0;
`endif

  assign mag_rnd_s = mag_s + {{OUT_W{1'b0}}, rnd_inc_s};

  // Rounded magnitude may exceed 2^(OUT_W-1)-1 (positive) or 2^(OUT_W-1) (negative).
  always_comb begin
    if (s2_sign_q) begin
      ovf_s = mag_rnd_s[OUT_W] | (mag_rnd_s[OUT_W-1] & (|mag_rnd_s[OUT_W-2:0]));
    end else begin
      ovf_s = mag_rnd_s[OUT_W] | mag_rnd_s[OUT_W-1];
    end
  end

  // Result and flags per class; negation follows rounding so it is symmetric.
  always_comb begin
    res_d   = {OUT_W{1'b0}};
    flags_d = '{invalid: 1'b0, overflow: 1'b0, inexact: 1'b0};
    case (s2_cls_q)
      CLS_ZERO: res_d = {OUT_W{1'b0}};
      CLS_SUB, CLS_TINY: flags_d.inexact = 1'b1;
      CLS_NAN: flags_d.invalid = 1'b1;
      CLS_INF, CLS_BIG: begin
        res_d            = s2_sign_q ? FIX_MIN : FIX_MAX;
        flags_d.overflow = 1'b1;
      end
      CLS_NORM: begin
        if (ovf_s) begin
          res_d            = s2_sign_q ? FIX_MIN : FIX_MAX;
          flags_d.overflow = 1'b1;
        end else begin
          res_d           = s2_sign_q ? ({OUT_W{1'b0}} - mag_rnd_s[OUT_W-1:0])
                                      : mag_rnd_s[OUT_W-1:0];
          flags_d.inexact = lost_s;
        end
      end
      default: res_d = {OUT_W{1'b0}};
    endcase
  end

  logic [OUT_W-1:0] m_tdata_q;
  fixp_flags_t      m_tuser_q;

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata_q <= {OUT_W{1'b0}};
      m_tuser_q <= '{invalid: 1'b0, overflow: 1'b0, inexact: 1'b0};
    end else if (adv2_s) begin
      m_tdata_q <= res_d;
      m_tuser_q <= flags_d;
    end else begin
      m_tdata_q <= m_tdata_q;
      m_tuser_q <= m_tuser_q;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tuser  = m_tuser_q;

endmodule

// File: tb/tb_fp64_to_fixp.sv
module tb_fp64_to_fixp;

  localparam int INT_W  = 32;
  localparam int FRAC_W = 32;
  localparam int OUT_W  = INT_W + FRAC_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tready, m_tvalid, m_tready;
  logic [63:0] s_tdata, m_tdata;
  logic [2:0]  m_tuser;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp64_to_fixp #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser)
  );

  // Reference: exact rational value M*2^k scaled to output LSBs, rounded by
  // quotient/remainder comparison against one half, then range-checked.
  function automatic logic [66:0] model(input logic [63:0] x);
    logic        sgn;
    logic [10:0] ex;
    logic [51:0] mt;
    logic [127:0] m, q, fr, half, maxp, maxn;
    logic [63:0] d, satv;
    logic        up, lost;
    int          k, n;
    sgn  = x[63];
    ex   = x[62:52];
    mt   = x[51:0];
    maxp = (128'd1 << (OUT_W - 1)) - 128'd1;
    maxn = 128'd1 << (OUT_W - 1);
    satv = sgn ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    if (ex == 11'h7FF) begin
      if (mt != 52'd0) return {3'b100, 64'd0};
      return {3'b010, satv};
    end
    if (ex == 11'd0) return {2'b00, (mt != 52'd0), 64'd0};
    m = {75'd0, 1'b1, mt};
    k = int'(ex) - 1023 - 52 + FRAC_W;
    if (k > 70) return {3'b010, satv};
    up   = 1'b0;
    lost = 1'b0;
    if (k >= 0) begin
      q = m << k;
    end else begin
      n = -k;
      if (n > 100) n = 100;
      q    = m >> n;
      fr   = m - (q << n);
      half = 128'd1 << (n - 1);
      lost = (fr != 128'd0);
`ifdef D2F_ROUND_NEAREST_EN
      up = (fr > half) || ((fr == half) && q[0]);
`endif
    end
    q = q + {127'd0, up};
    if ((!sgn && q > maxp) || (sgn && q > maxn)) return {3'b010, satv};
    d = q[63:0];
    if (sgn) d = 64'd0 - d;
    return {2'b00, lost, d};
  endfunction

  // ---------------- stream checker (samples on falling edge) ----------------
  logic [66:0] expq[$];
  logic        stall_p;
  logic [66:0] stall_v;

  initial begin
    logic [66:0] e;
    stall_p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        stall_p = 1'b0;
      end else begin
        if (stall_p) begin
          total++;
          if (!m_tvalid || {m_tuser, m_tdata} !== stall_v) begin
            bad++;
            $display("FAIL stall_hold: got v=%0b %h/%b want v=1 %h/%b", m_tvalid, m_tdata,
                     m_tuser, stall_v[63:0], stall_v[66:64]);
          end
        end
        if (m_tvalid && m_tready) begin
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got %h/%b want no beat", m_tdata, m_tuser);
          end else begin
            e = expq.pop_front();
            if ({m_tuser, m_tdata} !== e) begin
              bad++;
              $display("FAIL stream: got %h/%b want %h/%b", m_tdata, m_tuser, e[63:0], e[66:64]);
            end
          end
        end
        if (s_tvalid && s_tready) expq.push_back(model(s_tdata));
        stall_p = m_tvalid && !m_tready;
        stall_v = {m_tuser, m_tdata};
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [63:0] x;
    logic [63:0] d_rne;
    logic [63:0] d_tr;
    logic [2:0]  u;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV] = '{
    '{64'h3FF0_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 3'b000},
    '{64'hBFF8_0000_0000_0000, 64'hFFFF_FFFE_8000_0000, 64'hFFFF_FFFE_8000_0000, 3'b000},
    '{64'h4202_A05F_2000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010},
    '{64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010},
    '{64'hC1E0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000},
    '{64'h7FF8_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b100},
    '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b001},
    '{64'h3DE8_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 3'b001},
    '{64'h3DE0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b001},
    '{64'h41E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010},
    '{64'h7FF0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 3'b010},
    '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b000},
    '{64'h3DEF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 3'b001},
    '{64'hBDE8_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 3'b001},
    '{64'h3FB0_0000_0000_0000, 64'h0000_0000_1000_0000, 64'h0000_0000_1000_0000, 3'b000},
    '{64'h3DC0_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b001},
    '{64'h3DF0_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 3'b000},
    '{64'h3DF8_0000_0000_0000, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 3'b001}
  };

  task automatic run_vec(input int idx);
    logic [63:0] ed;
    logic [2:0]  eu;
    logic [66:0] mv;
    int          cyc, lat;
`ifdef D2F_ROUND_NEAREST_EN
    ed = vecs[idx].d_rne;
`else
    ed = vecs[idx].d_tr;
`endif
    eu = vecs[idx].u;
    mv = model(vecs[idx].x);
    total++;
    if (mv !== {eu, ed}) begin
      bad++;
      $display("FAIL model_vec%0d: got %h/%b want %h/%b", idx, mv[63:0], mv[66:64], ed, eu);
    end
    @(posedge clk); #1;
    s_tdata  = vecs[idx].x;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!s_tready && cyc < 20);
    // Count register edges from the accepting edge (edge 1) to m_tvalid.
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    lat = 1;
    while (!m_tvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != 3) begin
      bad++;
      $display("FAIL latency_vec%0d: got %0d want 3", idx, lat);
    end
    total++;
    if (m_tdata !== ed) begin
      bad++;
      $display("FAIL data_vec%0d: got %h want %h", idx, m_tdata, ed);
    end
    total++;
    if (m_tuser !== eu) begin
      bad++;
      $display("FAIL user_vec%0d: got %b want %b", idx, m_tuser, eu);
    end
  endtask

  function automatic logic [63:0] rnd_double();
    logic [10:0] ex;
    logic [63:0] mm;
    int          r;
    r  = $urandom_range(0, 19);
    mm = {$urandom, $urandom};
    if (r == 0) ex = 11'd0;
    else if (r == 1) ex = 11'h7FF;
    else if (r == 2) begin
      ex = 11'h7FF;
      mm = 64'd0;
    end else ex = 11'(978 + $urandom_range(0, 90));
    return {1'($urandom_range(0, 1)), ex, mm[51:0]};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int   sent, guard, wait_c;
    logic fired, did_rst;
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 64'd0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== 64'd0 || m_tuser !== 3'b000 || s_tready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b d=%h u=%b rdy=%0b want 0 0 000 0", m_tvalid, m_tdata,
               m_tuser, s_tready);
    end
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    sent    = 0;
    guard   = 0;
    fired   = 1'b0;
    did_rst = 1'b0;
    while (sent < 2000 && guard < 40000) begin
      @(posedge clk); #1;
      guard++;
      if (fired) sent++;
      if (sent == 1000 && !did_rst) begin
        did_rst  = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        total++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
          bad++;
          $display("FAIL mid_reset: got rdy=%0b v=%0b want 0 0", s_tready, m_tvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
      end
      if (!s_tvalid || fired) begin
        s_tvalid = 1'($urandom_range(0, 1));
        if (s_tvalid) s_tdata = rnd_double();
      end
      m_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      fired = s_tvalid && s_tready;
    end
    total++;
    if (sent < 2000) begin
      bad++;
      $display("FAIL random_budget: got %0d beats want 2000", sent);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_c = 0;
    while ((expq.size() != 0 || m_tvalid) && wait_c < 50) begin
      @(posedge clk); #1;
      wait_c++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
